// File: rtl/xgs_stream_scoreboard.sv
// Multi-channel stream scoreboard: per-channel expected FIFOs, masked compare of the
// actual stream against the FIFO head, saturating statistics and first-error capture.
module xgs_stream_scoreboard #(
  parameter int unsigned NUM_CH      = 4,
  parameter int unsigned DATA_W      = 64,
  parameter int unsigned DEPTH       = 16,
  parameter bit          STOP_ON_ERR = 1'b0,
  localparam int unsigned CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              sysclk,
  input  logic              sysrst_n,
  input  logic              clr,
  input  logic              exp_valid,
  output logic              exp_ready,
  input  logic [CH_W-1:0]   exp_ch,
  input  logic [DATA_W-1:0] exp_data,
  input  logic              exp_last,
  input  logic              act_valid,
  input  logic [CH_W-1:0]   act_ch,
  input  logic [DATA_W-1:0] act_data,
  input  logic              act_last,
  input  logic [DATA_W-1:0] cmp_mask,
  output logic [31:0]       match_cnt,
  output logic [31:0]       err_cnt,
  output logic [15:0]       unf_cnt,
  output logic [15:0]       ovf_cnt,
  output logic              first_err_vld,
  output logic [CH_W-1:0]   first_err_ch,
  output logic [DATA_W-1:0] first_err_exp,
  output logic [DATA_W-1:0] first_err_act,
  output logic [NUM_CH-1:0] fifo_empty,
  output logic              halted,
  output logic              idle
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_HALT} state_e;

  state_e            state_q;
  logic [AW:0]       cnt_q    [NUM_CH];
  logic [AW:0]       cnt_d    [NUM_CH];
  logic [AW-1:0]     wr_ptr_q [NUM_CH];
  logic [AW-1:0]     rd_ptr_q [NUM_CH];
  logic [DATA_W:0]   mem_q    [NUM_CH][DEPTH];

  logic              pend_vld_q, pend_err_q, pend_unf_q;
  logic [CH_W-1:0]   pend_ch_q;
  logic [DATA_W-1:0] pend_exp_q, pend_act_q;
  logic [31:0]       match_cnt_q, err_cnt_q;
  logic [15:0]       unf_cnt_q, ovf_cnt_q;
  logic              first_err_vld_q;
  logic [CH_W-1:0]   first_err_ch_q;
  logic [DATA_W-1:0] first_err_exp_q, first_err_act_q;

  logic [NUM_CH-1:0] empty, full, push_sel, pop_sel;
  logic              exp_ok, act_ok, push, pop, act_take, halt_now, cmp_err, all_empty_d;
  logic [CH_W-1:0]   exp_idx, act_idx;
  logic [DATA_W:0]   head;

  assign exp_ok    = 32'(exp_ch) < NUM_CH;
  assign act_ok    = 32'(act_ch) < NUM_CH;
  assign exp_idx   = exp_ok ? exp_ch : '0;
  assign act_idx   = act_ok ? act_ch : '0;
  assign exp_ready = exp_ok && !full[exp_idx] && (state_q != ST_HALT);
  assign push      = exp_valid && exp_ready && !clr;
  // An error result about to halt the block also blocks the word arriving in that cycle.
  assign halt_now  = STOP_ON_ERR && pend_vld_q && (pend_err_q || pend_unf_q);
  assign act_take  = act_valid && !clr && (state_q != ST_HALT) && !halt_now;
  assign pop       = act_take && act_ok && !empty[act_idx];
  assign head      = mem_q[act_idx][rd_ptr_q[act_idx]];
  assign cmp_err   = (|((act_data ^ head[DATA_W-1:0]) & cmp_mask)) || (act_last != head[DATA_W]);

  always_comb begin
    all_empty_d = 1'b1;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      empty[c]    = (cnt_q[c] == '0);
      full[c]     = (cnt_q[c] == FULL_CNT);
      push_sel[c] = push && (32'(exp_idx) == c);
      pop_sel[c]  = pop && (32'(act_idx) == c);
      cnt_d[c]    = cnt_q[c];
      if (push_sel[c] && !pop_sel[c])      cnt_d[c] = cnt_q[c] + 1'b1;
      else if (pop_sel[c] && !push_sel[c]) cnt_d[c] = cnt_q[c] - 1'b1;
      if (cnt_d[c] != '0) all_empty_d = 1'b0;
    end
  end

  always_ff @(posedge sysclk) begin
    if (push) mem_q[exp_idx][wr_ptr_q[exp_idx]] <= {exp_last, exp_data};
  end

  always_ff @(posedge sysclk or negedge sysrst_n) begin
    if (!sysrst_n || clr) begin
      state_q <= ST_IDLE;
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        cnt_q[c]    <= '0;
        wr_ptr_q[c] <= '0;
        rd_ptr_q[c] <= '0;
      end
      pend_vld_q      <= 1'b0;
      pend_err_q      <= 1'b0;
      pend_unf_q      <= 1'b0;
      pend_ch_q       <= '0;
      pend_exp_q      <= '0;
      pend_act_q      <= '0;
      match_cnt_q     <= '0;
      err_cnt_q       <= '0;
      unf_cnt_q       <= '0;
      ovf_cnt_q       <= '0;
      first_err_vld_q <= 1'b0;
      first_err_ch_q  <= '0;
      first_err_exp_q <= '0;
      first_err_act_q <= '0;
    end else begin
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        cnt_q[c] <= cnt_d[c];
        if (push_sel[c]) wr_ptr_q[c] <= wr_ptr_q[c] + 1'b1;
        if (pop_sel[c])  rd_ptr_q[c] <= rd_ptr_q[c] + 1'b1;
      end

      pend_vld_q <= act_take;
      pend_err_q <= pop && cmp_err;
      pend_unf_q <= act_take && !pop;
      pend_ch_q  <= act_ch;
      pend_exp_q <= pop ? head[DATA_W-1:0] : '0;
      pend_act_q <= act_data;

      if (pend_vld_q) begin
        if (pend_unf_q) begin
          if (unf_cnt_q != '1) unf_cnt_q <= unf_cnt_q + 1'b1;
        end else if (pend_err_q) begin
          if (err_cnt_q != '1) err_cnt_q <= err_cnt_q + 1'b1;
        end else begin
          if (match_cnt_q != '1) match_cnt_q <= match_cnt_q + 1'b1;
        end
        if ((pend_unf_q || pend_err_q) && !first_err_vld_q) begin
          first_err_vld_q <= 1'b1;
          first_err_ch_q  <= pend_ch_q;
          first_err_exp_q <= pend_exp_q;
          first_err_act_q <= pend_act_q;
        end
      end

      if (exp_valid && !exp_ready && (ovf_cnt_q != '1)) ovf_cnt_q <= ovf_cnt_q + 1'b1;

      case (state_q)
        ST_IDLE: if (push || act_take) state_q <= ST_RUN;
        ST_RUN: begin
          if (halt_now)                       state_q <= ST_HALT;
          else if (all_empty_d && !act_take)  state_q <= ST_IDLE;
        end
        default: ;
      endcase
    end
  end

  assign match_cnt     = match_cnt_q;
  assign err_cnt       = err_cnt_q;
  assign unf_cnt       = unf_cnt_q;
  assign ovf_cnt       = ovf_cnt_q;
  assign first_err_vld = first_err_vld_q;
  assign first_err_ch  = first_err_ch_q;
  assign first_err_exp = first_err_exp_q;
  assign first_err_act = first_err_act_q;
  assign fifo_empty    = empty;
  assign halted        = (state_q == ST_HALT);
  assign idle          = (state_q == ST_IDLE);
endmodule

// File: tb/tb_xgs_stream_scoreboard.sv
// Directed bench for xgs_stream_scoreboard: a default instance plus a STOP_ON_ERR=1
// instance sharing the same stimulus.
module tb_xgs_stream_scoreboard;
  logic        clk = 1'b0;
  logic        rst_n, clr;
  logic        exp_valid, exp_last, act_valid, act_last;
  logic [1:0]  exp_ch, act_ch;
  logic [63:0] exp_data, act_data, cmp_mask;

  logic        exp_ready, first_err_vld, halted, idle;
  logic [31:0] match_cnt, err_cnt;
  logic [15:0] unf_cnt, ovf_cnt;
  logic [1:0]  first_err_ch;
  logic [63:0] first_err_exp, first_err_act;
  logic [3:0]  fifo_empty;

  logic        h_exp_ready, h_first_err_vld, h_halted, h_idle;
  logic [31:0] h_match_cnt, h_err_cnt;
  logic [15:0] h_unf_cnt, h_ovf_cnt;
  logic [1:0]  h_first_err_ch;
  logic [63:0] h_first_err_exp, h_first_err_act;
  logic [3:0]  h_fifo_empty;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  xgs_stream_scoreboard #(.NUM_CH(4), .DATA_W(64), .DEPTH(16), .STOP_ON_ERR(1'b0)) dut (
    .sysclk(clk), .sysrst_n(rst_n), .clr(clr),
    .exp_valid(exp_valid), .exp_ready(exp_ready), .exp_ch(exp_ch), .exp_data(exp_data),
    .exp_last(exp_last), .act_valid(act_valid), .act_ch(act_ch), .act_data(act_data),
    .act_last(act_last), .cmp_mask(cmp_mask), .match_cnt(match_cnt), .err_cnt(err_cnt),
    .unf_cnt(unf_cnt), .ovf_cnt(ovf_cnt), .first_err_vld(first_err_vld),
    .first_err_ch(first_err_ch), .first_err_exp(first_err_exp), .first_err_act(first_err_act),
    .fifo_empty(fifo_empty), .halted(halted), .idle(idle)
  );

  xgs_stream_scoreboard #(.NUM_CH(4), .DATA_W(64), .DEPTH(16), .STOP_ON_ERR(1'b1)) dut_h (
    .sysclk(clk), .sysrst_n(rst_n), .clr(clr),
    .exp_valid(exp_valid), .exp_ready(h_exp_ready), .exp_ch(exp_ch), .exp_data(exp_data),
    .exp_last(exp_last), .act_valid(act_valid), .act_ch(act_ch), .act_data(act_data),
    .act_last(act_last), .cmp_mask(cmp_mask), .match_cnt(h_match_cnt), .err_cnt(h_err_cnt),
    .unf_cnt(h_unf_cnt), .ovf_cnt(h_ovf_cnt), .first_err_vld(h_first_err_vld),
    .first_err_ch(h_first_err_ch), .first_err_exp(h_first_err_exp),
    .first_err_act(h_first_err_act), .fifo_empty(h_fifo_empty), .halted(h_halted), .idle(h_idle)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [1:0] ch, input logic [63:0] d, input logic last);
    exp_valid = 1'b1; exp_ch = ch; exp_data = d; exp_last = last;
    tick();
    exp_valid = 1'b0;
  endtask

  task automatic act(input logic [1:0] ch, input logic [63:0] d, input logic last,
                     input logic [63:0] mask);
    act_valid = 1'b1; act_ch = ch; act_data = d; act_last = last; cmp_mask = mask;
    tick();
    act_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; clr = 1'b0;
    exp_valid = 1'b0; exp_ch = '0; exp_data = '0; exp_last = 1'b0;
    act_valid = 1'b0; act_ch = '0; act_data = '0; act_last = 1'b0; cmp_mask = '1;
    #2;
    check_eq("rst_exp_ready", exp_ready, 1'b1);
    check_eq("rst_idle", idle, 1'b1);
    check_eq("rst_halted", halted, 1'b0);
    check_eq("rst_fifo_empty", fifo_empty, 4'hF);
    check_eq("rst_match", match_cnt, 0);
    check_eq("rst_first_err_vld", first_err_vld, 1'b0);
    #11 rst_n = 1'b1;
    tick();

    // single match on ch1
    push(2'd1, 64'hA5, 1'b0);
    check_eq("push_fifo_empty", fifo_empty, 4'b1101);
    check_eq("push_not_idle", idle, 1'b0);
    act(2'd1, 64'hA5, 1'b0, '1);
    check_eq("match_latency", match_cnt, 0);
    tick();
    check_eq("match_cnt1", match_cnt, 1);
    check_eq("match_err0", err_cnt, 0);
    tick();
    check_eq("match_idle", idle, 1'b1);

    // masked compare, then full-mask mismatch
    push(2'd0, 64'h00FF, 1'b0);
    act(2'd0, 64'h0FFF, 1'b0, 64'h00FF);
    tick();
    check_eq("mask_match", match_cnt, 2);
    check_eq("mask_err0", err_cnt, 0);
    push(2'd0, 64'h00FF, 1'b0);
    act(2'd0, 64'h0FFF, 1'b0, 64'hFFFF);
    tick();
    check_eq("mask_err1", err_cnt, 1);
    check_eq("fe_vld", first_err_vld, 1'b1);
    check_eq("fe_ch", first_err_ch, 2'd0);
    check_eq("fe_exp", first_err_exp, 64'h00FF);
    check_eq("fe_act", first_err_act, 64'h0FFF);
    // last-flag mismatch must count but leave the first-error record alone
    push(2'd2, 64'h5, 1'b1);
    act(2'd2, 64'h5, 1'b0, '1);
    tick();
    check_eq("last_err", err_cnt, 2);
    check_eq("fe_hold_exp", first_err_exp, 64'h00FF);
    check_eq("fe_hold_ch", first_err_ch, 2'd0);

    // fill ch2, overflow attempt, drain in order across the pointer wrap
    for (int i = 0; i < 16; i++) push(2'd2, 64'h200 + 64'(i), (i == 15));
    exp_ch = 2'd2; #1;
    check_eq("full_ready_ch2", exp_ready, 1'b0);
    exp_ch = 2'd3; #1;
    check_eq("full_ready_ch3", exp_ready, 1'b1);
    push(2'd2, 64'hDEAD, 1'b0);
    check_eq("ovf_cnt", ovf_cnt, 1);
    for (int i = 0; i < 16; i++) act(2'd2, 64'h200 + 64'(i), (i == 15), '1);
    tick();
    check_eq("drain_match", match_cnt, 18);
    check_eq("drain_err", err_cnt, 2);
    check_eq("drain_empty", fifo_empty, 4'hF);

    // act on empty ch3 together with a push to ch3
    exp_valid = 1'b1; exp_ch = 2'd3; exp_data = 64'h33; exp_last = 1'b0;
    act_valid = 1'b1; act_ch = 2'd3; act_data = 64'h33; act_last = 1'b0; cmp_mask = '1;
    tick();
    exp_valid = 1'b0; act_valid = 1'b0;
    check_eq("unf_stored", fifo_empty[3], 1'b0);
    tick();
    check_eq("unf_cnt", unf_cnt, 1);
    check_eq("unf_no_err", err_cnt, 2);
    act(2'd3, 64'h33, 1'b0, '1);
    tick();
    check_eq("unf_word_kept", match_cnt, 19);

    // clear, then halt behaviour on the STOP_ON_ERR instance
    clr = 1'b1; tick(); clr = 1'b0;
    check_eq("clr_match", match_cnt, 0);
    check_eq("clr_err", err_cnt, 0);
    check_eq("clr_unf", unf_cnt, 0);
    check_eq("clr_ovf", ovf_cnt, 0);
    check_eq("clr_fe_vld", first_err_vld, 1'b0);
    check_eq("clr_idle", idle, 1'b1);
    check_eq("h_clr_halted", h_halted, 1'b0);
    push(2'd0, 64'h11, 1'b0);
    act(2'd0, 64'h12, 1'b0, '1);
    tick();
    exp_ch = 2'd0; #1;
    check_eq("h_halted", h_halted, 1'b1);
    check_eq("h_idle_low", h_idle, 1'b0);
    check_eq("h_exp_ready", h_exp_ready, 1'b0);
    check_eq("h_err1", h_err_cnt, 1);
    act(2'd0, 64'h12, 1'b0, '1);
    act(2'd1, 64'h13, 1'b0, '1);
    tick();
    check_eq("h_err_frozen", h_err_cnt, 1);
    check_eq("h_unf_frozen", h_unf_cnt, 0);
    check_eq("h_match_frozen", h_match_cnt, 0);
    clr = 1'b1; tick(); clr = 1'b0;
    check_eq("h_clr_err", h_err_cnt, 0);
    check_eq("h_clr_idle", h_idle, 1'b1);
    check_eq("h_clr_unhalt", h_halted, 1'b0);

    // reset with words queued and a compare in flight
    for (int i = 0; i < 6; i++) push(2'd0, 64'h100 + 64'(i), 1'b0);
    act(2'd0, 64'h100, 1'b0, '1);
    check_eq("pre_rst_queued", fifo_empty[0], 1'b0);
    #1 rst_n = 1'b0;
    #1;
    check_eq("mid_rst_empty", fifo_empty, 4'hF);
    check_eq("mid_rst_idle", idle, 1'b1);
    check_eq("mid_rst_ready", exp_ready, 1'b1);
    #1 rst_n = 1'b1;
    tick();
    tick();
    check_eq("post_rst_match", match_cnt, 0);
    check_eq("post_rst_err", err_cnt, 0);
    check_eq("post_rst_empty", fifo_empty, 4'hF);
    check_eq("post_rst_fe", first_err_vld, 1'b0);
    check_eq("post_rst_idle", idle, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/xgs_stream_scoreboard.md
XGS_STREAM_SCOREBOARD -- requirements
Module: xgs_stream_scoreboard

Interface
REQ-001 The block SHALL have parameter NUM_CH, default 4: number of independent compare channels, range 1..16.
REQ-002 The block SHALL have parameter DATA_W, default 64: data width in bits.
REQ-003 The block SHALL have parameter DEPTH, default 16: expected-FIFO depth per channel, a power of 2 and at least 2.
REQ-004 The block SHALL have parameter STOP_ON_ERR, default 0: when 1, the first error halts the block.
REQ-005 The block SHALL have the following ports, with CH_W = max(1,clog2(NUM_CH)):
- sysclk  in  1  single clock; all logic on its rising edge.
- sysrst_n  in  1  asynchronous active-low reset.
- clr  in  1  synchronous clear of FIFOs, counters, capture and state.
- exp_valid  in  1  expected word valid.
- exp_ready  out  1  expected word accepted when high together with exp_valid.
- exp_ch  in  CH_W  channel of the expected word.
- exp_data  in  DATA_W  expected data.
- exp_last  in  1  expected end-of-line marker.
- act_valid  in  1  actual word valid; there is no backpressure on this stream.
- act_ch  in  CH_W  channel of the actual word.
- act_data  in  DATA_W  actual data.
- act_last  in  1  actual end-of-line marker.
- cmp_mask  in  DATA_W  bits set to 1 are compared; sampled with act_valid.
- match_cnt  out  32  count of matching words.
- err_cnt  out  32  count of mismatching words.
- unf_cnt  out  16  count of actual words that arrived while their channel FIFO was empty.
- ovf_cnt  out  16  count of words with exp_valid high and exp_ready low.
- first_err_vld  out  1  a first-error record has been captured.
- first_err_ch  out  CH_W  channel of the first error.
- first_err_exp  out  DATA_W  expected data of the first error.
- first_err_act  out  DATA_W  actual data of the first error.
- fifo_empty  out  NUM_CH  per-channel FIFO empty flag.
- halted  out  1  block is in the HALT state.
- idle  out  1  all FIFOs empty and no compare is in flight.

Function
REQ-006 Each channel SHALL own a DEPTH-entry FIFO that stores {exp_last, exp_data}; a write occurs when exp_valid and exp_ready are both high.
REQ-007 exp_ready SHALL equal NOT full[exp_ch] AND NOT halted; it is combinational from exp_ch and registered state.
REQ-008 When act_valid is high and fifo_empty[act_ch] is 0, the block SHALL pop that channel's FIFO head in the same cycle.
REQ-009 The compare SHALL be registered: ((act_data XOR head_data) AND cmp_mask) != 0, OR act_last != head_last, is an error.
REQ-010 The result SHALL update match_cnt or err_cnt exactly 1 cycle after the accepting edge.
REQ-011 When act_valid is high and the FIFO is empty, the block SHALL NOT pop, SHALL increment unf_cnt one cycle later, and SHALL treat the event as an error for first-error capture with first_err_exp=0.
REQ-012 A push and an actual word to the same empty channel in the same cycle SHALL count as an underflow, with no bypass; the pushed word SHALL still be stored.
REQ-013 Simultaneous push and pop on a full channel SHALL be refused, because exp_ready=0; only the pop SHALL occur.
REQ-014 FIFO pointers SHALL wrap modulo DEPTH; the occupancy counter SHALL be log2(DEPTH)+1 bits wide.
REQ-015 All counters SHALL saturate at their all-ones value and never wrap.
REQ-016 The first error SHALL be captured once; later errors SHALL leave the capture unchanged until clr or reset.
REQ-017 The state machine SHALL have the states IDLE, RUN and HALT, with these transitions:
- IDLE->RUN on any accepted exp or act word.
- RUN->IDLE when all FIFOs are empty and no compare is pending.
- RUN->HALT on an error or underflow result when STOP_ON_ERR=1.
- HALT->IDLE only on clr.
REQ-018 In HALT, act words SHALL be ignored: no pop and no counter change.
REQ-019 idle SHALL be 1 only in IDLE; halted SHALL be 1 only in HALT.
REQ-020 clr SHALL take priority over all same-cycle traffic: words in that cycle are discarded and nothing is counted.
REQ-021 An act_ch or exp_ch value of NUM_CH or greater SHALL be discarded: exp_ready=0 for such a word, and an act word on such a channel increments unf_cnt.

Reset
REQ-022 On sysrst_n low the block SHALL asynchronously clear to: all FIFOs empty, fifo_empty all ones, all counters 0, first_err_* 0, state IDLE, idle=1, halted=0.
REQ-023 exp_ready SHALL be 1 during reset.
REQ-024 Reset asserted mid-operation SHALL discard any in-flight compare result.

Verification
REQ-025 The bench SHALL cover: push 0xA5 to ch1, then act 0xA5 on ch1 -> match_cnt=1 one cycle after act, err_cnt=0, idle=1 on the following cycle.
REQ-026 The bench SHALL cover: push 0x00FF to ch0, then act 0x0FFF with cmp_mask=0x00FF -> match; repeat with mask 0xFFFF -> err_cnt=1, first_err_ch=0, first_err_exp=0x00FF, first_err_act=0x0FFF.
REQ-027 The bench SHALL cover: push DEPTH words to ch2 -> exp_ready=0 for ch2 and still 1 for ch3; one further exp_valid on ch2 -> ovf_cnt=1.
REQ-028 The bench SHALL cover: act on empty ch3 in the same cycle as a push to ch3 -> unf_cnt=1, fifo_empty[3]=0.
REQ-029 The bench SHALL cover: with STOP_ON_ERR=1, a mismatch -> halted=1 and exp_ready=0; further act words leave the counters unchanged; clr -> all counters 0 and idle=1.
REQ-030 The bench SHALL cover: assert sysrst_n low while 5 words sit in ch0 and a compare is pending -> all outputs at reset values, with no counter increment after release.
